// File: rtl/tbi_rx_sync_monitor.sv
// TBI receive monitor: comma detection, simplified cl.36 sync FSM and error statistics.
// Define TBI_RX_SYNC_STATS_EN to build the sync-loss counter behind los_cnt_o.
module tbi_rx_sync_monitor #(
  parameter int g_commas_to_sync  = 3,
  parameter int g_good_to_recover = 4,
  parameter int g_max_err_lvl     = 4,
  parameter int g_cnt_width       = 16
) (
  input  logic                   clk_ref_i,
  input  logic                   rst_i,
  input  logic [9:0]             rx_data_i,
  input  logic                   clr_cnt_i,
  output logic                   sync_o,
  output logic                   comma_o,
  output logic                   code_err_o,
  output logic [2:0]             err_lvl_o,
  output logic [g_cnt_width-1:0] err_cnt_o,
  output logic [g_cnt_width-1:0] los_cnt_o
);

  typedef enum logic [1:0] {LOS, CDET, SYNC_ACQ, SYNC_ERR} state_t;

  localparam logic [2:0] COMMAS_TO_SYNC  = 3'(g_commas_to_sync);
  localparam logic [3:0] GOOD_TO_RECOVER = 4'(g_good_to_recover);
  localparam logic [2:0] MAX_ERR_LVL     = 3'(g_max_err_lvl);
  localparam logic [g_cnt_width-1:0] CNT_ONE = {{(g_cnt_width-1){1'b0}}, 1'b1};

  logic [3:0] ones;
  logic       is_comma;
  logic       is_invalid;

  always_comb begin
    ones = '0;
    for (int i = 0; i < 10; i++) ones = ones + {3'b000, rx_data_i[i]};
  end

  // Commas can carry up to 8 ones but are never flagged as disparity errors.
  assign is_comma   = (rx_data_i[9:3] == 7'b0011111) || (rx_data_i[9:3] == 7'b1100000);
  assign is_invalid = !is_comma && ((ones < 4'd4) || (ones > 4'd6));

  state_t     state, state_nxt;
  logic [2:0] ccnt, ccnt_nxt;
  logic [3:0] good, good_nxt;
  logic [2:0] err_lvl, err_lvl_nxt;

  always_ff @(posedge clk_ref_i) begin
    if (rst_i) begin
      state   <= LOS;
      ccnt    <= '0;
      good    <= '0;
      err_lvl <= '0;
    end else begin
      state   <= state_nxt;
      ccnt    <= ccnt_nxt;
      good    <= good_nxt;
      err_lvl <= err_lvl_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ccnt_nxt    = ccnt;
    good_nxt    = good;
    err_lvl_nxt = err_lvl;
    case (state)
      LOS: begin
        if (is_comma) begin
          if (COMMAS_TO_SYNC <= 3'd1) begin
            state_nxt = SYNC_ACQ;
            ccnt_nxt  = '0;
          end else begin
            state_nxt = CDET;
            ccnt_nxt  = 3'd1;
          end
        end
      end
      CDET: begin
        if (is_invalid) begin
          state_nxt = LOS;
          ccnt_nxt  = '0;
        end else if (is_comma) begin
          if (ccnt + 3'd1 == COMMAS_TO_SYNC) begin
            state_nxt = SYNC_ACQ;
            ccnt_nxt  = '0;
          end else begin
            ccnt_nxt = ccnt + 3'd1;
          end
        end
      end
      SYNC_ACQ: begin
        if (is_invalid) begin
          good_nxt = '0;
          // A threshold of 1 means the first error already drops the link.
          if (MAX_ERR_LVL <= 3'd1) begin
            state_nxt = LOS;
          end else begin
            state_nxt   = SYNC_ERR;
            err_lvl_nxt = 3'd1;
          end
        end
      end
      SYNC_ERR: begin
        if (is_invalid) begin
          good_nxt = '0;
          if (err_lvl + 3'd1 == MAX_ERR_LVL) begin
            state_nxt   = LOS;
            err_lvl_nxt = '0;
          end else begin
            err_lvl_nxt = err_lvl + 3'd1;
          end
        end else if (good + 4'd1 == GOOD_TO_RECOVER) begin
          good_nxt    = '0;
          err_lvl_nxt = err_lvl - 3'd1;
          if (err_lvl == 3'd1) state_nxt = SYNC_ACQ;
        end else begin
          good_nxt = good + 4'd1;
        end
      end
      default: state_nxt = LOS;
    endcase
  end

  assign sync_o    = (state == SYNC_ACQ) || (state == SYNC_ERR);
  assign err_lvl_o = err_lvl;

  always_ff @(posedge clk_ref_i) begin
    if (rst_i) begin
      comma_o    <= 1'b0;
      code_err_o <= 1'b0;
    end else begin
      comma_o    <= is_comma;
      code_err_o <= is_invalid;
    end
  end

  always_ff @(posedge clk_ref_i) begin
    if (rst_i || clr_cnt_i)
      err_cnt_o <= '0;
    else if (is_invalid && (err_cnt_o != '1))
      err_cnt_o <= err_cnt_o + CNT_ONE;
  end

`ifdef TBI_RX_SYNC_STATS_EN
  logic los_evt;

  assign los_evt = sync_o && (state_nxt == LOS);

  always_ff @(posedge clk_ref_i) begin
    if (rst_i || clr_cnt_i)
      los_cnt_o <= '0;
    else if (los_evt && (los_cnt_o != '1))
      los_cnt_o <= los_cnt_o + CNT_ONE;
  end
`else
  assign los_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tbi_rx_sync_monitor.sv
// Bench for tbi_rx_sync_monitor: directed scenarios plus randomized code-group streams
// checked against a rule-level model; a second instance exercises narrow counters.
module tb_tbi_rx_sync_monitor;

  localparam int CTS  = 3;
  localparam int REC  = 4;
  localparam int MAXL = 4;
  localparam int W    = 16;
  localparam int W4   = 4;

`ifdef TBI_RX_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [9:0]    rxd = '0;
  logic          sync, comma, cerr;
  logic [2:0]    lvl;
  logic [W-1:0]  ecnt, lcnt;
  logic          sync4, comma4, cerr4;
  logic [2:0]    lvl4;
  logic [W4-1:0] ecnt4, lcnt4;

  tbi_rx_sync_monitor #(
    .g_commas_to_sync(CTS), .g_good_to_recover(REC), .g_max_err_lvl(MAXL), .g_cnt_width(W)
  ) dut (
    .clk_ref_i(clk), .rst_i(rst), .rx_data_i(rxd), .clr_cnt_i(clr),
    .sync_o(sync), .comma_o(comma), .code_err_o(cerr), .err_lvl_o(lvl),
    .err_cnt_o(ecnt), .los_cnt_o(lcnt)
  );

  tbi_rx_sync_monitor #(
    .g_commas_to_sync(CTS), .g_good_to_recover(REC), .g_max_err_lvl(MAXL), .g_cnt_width(W4)
  ) dut_w4 (
    .clk_ref_i(clk), .rst_i(rst), .rx_data_i(rxd), .clr_cnt_i(clr),
    .sync_o(sync4), .comma_o(comma4), .code_err_o(cerr4), .err_lvl_o(lvl4),
    .err_cnt_o(ecnt4), .los_cnt_o(lcnt4)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: link is either hunting (counting commas) or in sync with an error level.
  bit m_sync, m_comma, m_cerr;
  int m_commas, m_lvl, m_good, m_err, m_err4, m_los, m_los4;

  function automatic bit f_comma(input logic [9:0] d);
    return (d[9:3] == 7'b0011111) || (d[9:3] == 7'b1100000);
  endfunction

  function automatic bit f_bad(input logic [9:0] d);
    int n;
    n = $countones(d);
    return !f_comma(d) && (n < 4 || n > 6);
  endfunction

  task automatic model_update(input logic [9:0] d, input bit c, input bit r);
    bit cm, bd, lost;
    if (r) begin
      m_sync = 0; m_comma = 0; m_cerr = 0;
      m_commas = 0; m_lvl = 0; m_good = 0;
      m_err = 0; m_err4 = 0; m_los = 0; m_los4 = 0;
      return;
    end
    cm = f_comma(d);
    bd = f_bad(d);
    lost = 0;
    m_comma = cm;
    m_cerr  = bd;
    if (!m_sync) begin
      if (bd) m_commas = 0;
      else if (cm) begin
        m_commas++;
        if (m_commas >= CTS) begin m_sync = 1; m_commas = 0; end
      end
    end else if (bd) begin
      m_good = 0;
      if (m_lvl + 1 >= MAXL) begin m_sync = 0; m_lvl = 0; lost = 1; end
      else m_lvl++;
    end else if (m_lvl > 0) begin
      m_good++;
      if (m_good == REC) begin m_good = 0; m_lvl--; end
    end
    if (c) begin
      m_err = 0; m_err4 = 0; m_los = 0; m_los4 = 0;
    end else begin
      if (bd) begin
        if (m_err  < (1 << W)  - 1) m_err++;
        if (m_err4 < (1 << W4) - 1) m_err4++;
      end
      if (lost) begin
        if (m_los  < (1 << W)  - 1) m_los++;
        if (m_los4 < (1 << W4) - 1) m_los4++;
      end
    end
  endtask

  task automatic step(input logic [9:0] d, input bit c, input bit r);
    rxd = d; clr = c; rst = r;
    @(posedge clk);
    model_update(d, c, r);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 10; i++) step(10'($urandom), 1'b0, 1'b1);
    checks++; if (sync  !== 1'b0) begin errors++; $display("FAIL reset_sync got %0b exp 0", sync); end
    checks++; if (comma !== 1'b0) begin errors++; $display("FAIL reset_comma got %0b exp 0", comma); end
    checks++; if (cerr  !== 1'b0) begin errors++; $display("FAIL reset_code_err got %0b exp 0", cerr); end
    checks++; if (lvl   !== 3'd0) begin errors++; $display("FAIL reset_err_lvl got %0d exp 0", lvl); end
    checks++; if (ecnt  !== '0)   begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", ecnt); end
    checks++; if (lcnt  !== '0)   begin errors++; $display("FAIL reset_los_cnt got %0d exp 0", lcnt); end
  endtask

  task automatic test_acquire;
    step(10'h0FA, 1'b0, 1'b0);
    step(10'h305, 1'b0, 1'b0);
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL acq_early_sync got %0b exp 0", sync); end
    step(10'h0FA, 1'b0, 1'b0);
    checks++; if (sync  !== 1'b1) begin errors++; $display("FAIL acq_sync got %0b exp 1", sync); end
    checks++; if (comma !== 1'b1) begin errors++; $display("FAIL acq_comma got %0b exp 1", comma); end
    checks++; if (ecnt  !== '0)   begin errors++; $display("FAIL acq_err_cnt got %0d exp 0", ecnt); end
  endtask

  task automatic test_recover;
    step(10'h3FF, 1'b0, 1'b0);
    checks++; if (cerr !== 1'b1) begin errors++; $display("FAIL rec_code_err got %0b exp 1", cerr); end
    checks++; if (lvl  !== 3'd1) begin errors++; $display("FAIL rec_lvl_up got %0d exp 1", lvl); end
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL rec_sync_err got %0b exp 1", sync); end
    step(10'h0FA, 1'b0, 1'b0);
    checks++; if (cerr !== 1'b0) begin errors++; $display("FAIL rec_strobe got %0b exp 0", cerr); end
    step(10'h305, 1'b0, 1'b0);
    step(10'h0FA, 1'b0, 1'b0);
    checks++; if (lvl !== 3'd1) begin errors++; $display("FAIL rec_lvl_hold got %0d exp 1", lvl); end
    step(10'h305, 1'b0, 1'b0);
    checks++; if (lvl  !== 3'd0) begin errors++; $display("FAIL rec_lvl_down got %0d exp 0", lvl); end
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL rec_sync got %0b exp 1", sync); end
    checks++; if (ecnt !== 16'd1) begin errors++; $display("FAIL rec_err_cnt got %0d exp 1", ecnt); end
  endtask

  task automatic test_loss;
    step(10'h0FA, 1'b1, 1'b0);
    checks++; if (ecnt !== '0) begin errors++; $display("FAIL loss_clr got %0d exp 0", ecnt); end
    for (int i = 0; i < 3; i++) step(10'h3FF, 1'b0, 1'b0);
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL loss_hold_sync got %0b exp 1", sync); end
    checks++; if (lvl  !== 3'd3) begin errors++; $display("FAIL loss_lvl3 got %0d exp 3", lvl); end
    step(10'h3FF, 1'b0, 1'b0);
    checks++; if (sync !== 1'b0)  begin errors++; $display("FAIL loss_sync got %0b exp 0", sync); end
    checks++; if (lvl  !== 3'd0)  begin errors++; $display("FAIL loss_lvl got %0d exp 0", lvl); end
    checks++; if (ecnt !== 16'd4) begin errors++; $display("FAIL loss_err_cnt got %0d exp 4", ecnt); end
    checks++; if (lcnt !== W'(STATS)) begin errors++; $display("FAIL loss_los_cnt got %0d exp %0d", lcnt, STATS); end
  endtask

  task automatic test_cdet_restart;
    step(10'h0FA, 1'b0, 1'b0);
    step(10'h000, 1'b0, 1'b0);
    checks++; if (cerr !== 1'b1) begin errors++; $display("FAIL cdet_code_err got %0b exp 1", cerr); end
    step(10'h305, 1'b0, 1'b0);
    step(10'h0FA, 1'b0, 1'b0);
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL cdet_no_sync got %0b exp 0", sync); end
    step(10'h305, 1'b0, 1'b0);
    step(10'h0FA, 1'b0, 1'b0);
    step(10'h305, 1'b0, 1'b0);
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL cdet_resync got %0b exp 1", sync); end
  endtask

  task automatic test_saturate_clear;
    step(10'h0FA, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(10'h3FF, 1'b0, 1'b0);
    checks++; if (ecnt4 !== 4'hF)  begin errors++; $display("FAIL sat_err_cnt_w4 got %0h exp f", ecnt4); end
    checks++; if (ecnt  !== 16'd20) begin errors++; $display("FAIL sat_err_cnt got %0d exp 20", ecnt); end
    checks++; if (lcnt4 !== W4'(STATS)) begin errors++; $display("FAIL sat_los_cnt_w4 got %0d exp %0d", lcnt4, STATS); end
    step(10'h3FF, 1'b1, 1'b0);
    checks++; if (ecnt4 !== '0) begin errors++; $display("FAIL clr_err_cnt_w4 got %0h exp 0", ecnt4); end
    checks++; if (ecnt  !== '0) begin errors++; $display("FAIL clr_err_cnt got %0d exp 0", ecnt); end
    checks++; if (lcnt4 !== '0) begin errors++; $display("FAIL clr_los_cnt_w4 got %0d exp 0", lcnt4); end
  endtask

  task automatic test_reset_midop;
    step(10'h0FA, 1'b0, 1'b0);
    step(10'h305, 1'b0, 1'b0);
    step(10'h0FA, 1'b0, 1'b0);
    step(10'h3FF, 1'b0, 1'b0);
    checks++; if (lvl !== 3'd1) begin errors++; $display("FAIL mid_sync_err got %0d exp 1", lvl); end
    step(10'h0FA, 1'b1, 1'b1);
    checks++; if (sync  !== 1'b0) begin errors++; $display("FAIL mid_sync got %0b exp 0", sync); end
    checks++; if (lvl   !== 3'd0) begin errors++; $display("FAIL mid_lvl got %0d exp 0", lvl); end
    checks++; if (comma !== 1'b0) begin errors++; $display("FAIL mid_comma got %0b exp 0", comma); end
    checks++; if (ecnt  !== '0)   begin errors++; $display("FAIL mid_err_cnt got %0d exp 0", ecnt); end
    step(10'h305, 1'b0, 1'b0);
    step(10'h0FA, 1'b0, 1'b0);
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL mid_hunt got %0b exp 0", sync); end
    step(10'h305, 1'b0, 1'b0);
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL mid_resync got %0b exp 1", sync); end
  endtask

  task automatic test_random;
    int         sel;
    logic [9:0] d;
    bit         c, r;
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(99);
      if (sel < 40) begin
        d = {($urandom_range(1) == 1) ? 7'b0011111 : 7'b1100000, 3'($urandom)};
      end else if (sel < 88) begin
        d = 10'($urandom);
        for (int k = 0; k < 32 && (f_bad(d) || f_comma(d)); k++) d = 10'($urandom);
      end else if (sel < 94) begin
        d = 10'h3FF;
      end else begin
        d = 10'($urandom);
      end
      c = ($urandom_range(99) < 3);
      r = ($urandom_range(299) == 0);
      step(d, c, r);
      checks++; if (sync !== m_sync) begin errors++; $display("FAIL rnd_sync cyc %0d got %0b exp %0b", i, sync, m_sync); end
      checks++; if (comma !== m_comma) begin errors++; $display("FAIL rnd_comma cyc %0d got %0b exp %0b", i, comma, m_comma); end
      checks++; if (cerr !== m_cerr) begin errors++; $display("FAIL rnd_code_err cyc %0d got %0b exp %0b", i, cerr, m_cerr); end
      checks++; if (lvl !== 3'(m_lvl)) begin errors++; $display("FAIL rnd_err_lvl cyc %0d got %0d exp %0d", i, lvl, m_lvl); end
      checks++; if (ecnt !== W'(m_err)) begin errors++; $display("FAIL rnd_err_cnt cyc %0d got %0d exp %0d", i, ecnt, m_err); end
      checks++; if (lcnt !== (STATS ? W'(m_los) : W'(0))) begin errors++; $display("FAIL rnd_los_cnt cyc %0d got %0d exp %0d", i, lcnt, STATS ? m_los : 0); end
      checks++; if (ecnt4 !== W4'(m_err4)) begin errors++; $display("FAIL rnd_err_cnt_w4 cyc %0d got %0d exp %0d", i, ecnt4, m_err4); end
      checks++; if (lcnt4 !== (STATS ? W4'(m_los4) : W4'(0))) begin errors++; $display("FAIL rnd_los_cnt_w4 cyc %0d got %0d exp %0d", i, lcnt4, STATS ? m_los4 : 0); end
      checks++;
      if ({sync4, comma4, cerr4, lvl4} !== {m_sync, m_comma, m_cerr, 3'(m_lvl)}) begin
        errors++;
        $display("FAIL rnd_w4_status cyc %0d got %b exp %b", i, {sync4, comma4, cerr4, lvl4},
                 {m_sync, m_comma, m_cerr, 3'(m_lvl)});
      end
    end
  endtask

  initial begin
    test_reset;
    test_acquire;
    test_recover;
    test_loss;
    test_cdet_restart;
    test_saturate_clear;
    test_reset_midop;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
